// File: rtl/axis_slave_fifo_if.sv
// ----------------------------------------------------------------------------
// axis_slave_fifo_if
//
// Purpose : Bundles the two handshake buses of axis_slave_fifo.
//           - axis_* : upstream AXI-Stream beat channel (master -> FIFO)
//           - bk_*   : backend consumer channel (FIFO -> user logic)
//
// Modports:
//   master : the environment around the FIFO. It drives the AXIS beat and
//            bk_ready, and observes axis_tready and the bk_* head outputs.
//   slave  : the FIFO itself. It is the mirror image of master.
//
// Parameters:
//   DATA_WIDTH : tdata width in bits (multiple of 8)
//   USER_WIDTH : tuser width in bits
// ----------------------------------------------------------------------------
interface axis_slave_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Upstream AXI-Stream channel
    logic                  axis_tvalid;
    logic [DATA_WIDTH-1:0] axis_tdata;
    logic [STRB_WIDTH-1:0] axis_tstrb;
    logic [STRB_WIDTH-1:0] axis_tkeep;
    logic                  axis_tlast;
    logic [USER_WIDTH-1:0] axis_tuser;
    logic                  axis_tready;

    // Backend consumer channel
    logic [DATA_WIDTH-1:0] bk_data;
    logic [STRB_WIDTH-1:0] bk_tstrb;
    logic [STRB_WIDTH-1:0] bk_tkeep;
    logic [USER_WIDTH-1:0] bk_user;
    logic                  bk_tlast;
    logic                  bk_valid;
    logic                  bk_ready;

    modport master (
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
        input  axis_tready,
        input  bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
        output bk_ready
    );

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
        output axis_tready,
        output bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
        input  bk_ready
    );
endinterface

// File: rtl/axis_slave_fifo.sv
// ----------------------------------------------------------------------------
// axis_slave_fifo
//
// Purpose : AXI-Stream slave front end. Beats accepted from the upstream AXIS
//           master are stored in a DEPTH-entry FIFO and presented, in arrival
//           order, to a backend consumer over a valid/ready channel. The head
//           entry is visible on bk_* right after the edge that wrote it into
//           an empty FIFO, and one beat per cycle can stream through when the
//           backend is always ready.
//
// Ports:
//   axi_aclk    : clock
//   axi_aresetn : asynchronous, active-low reset
//   flush       : synchronous flush; discards every stored beat
//   bus         : axis_slave_fifo_if.slave (axis_* upstream, bk_* backend)
//   fifo_count  : current occupancy, 0..DEPTH
//
// Parameters:
//   DATA_WIDTH : tdata width (multiple of 8); tstrb/tkeep are DATA_WIDTH/8
//   USER_WIDTH : tuser width
//   DEPTH      : number of entries, power of two, >= 2
//   CNT_WIDTH  : occupancy counter width (derived)
//
// Build option:
//   AXIS_SLAVE_FIFO_NULL_DROP_EN : when defined, a beat with tkeep == 0 and
//   tlast == 0 is handshaken but not stored. A null beat carrying tlast is
//   still stored so the packet boundary reaches the backend.
// ----------------------------------------------------------------------------
module axis_slave_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int USER_WIDTH = 2,
    parameter  int DEPTH      = 4,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 flush,
    axis_slave_fifo_if.slave     bus,
    output logic [CNT_WIDTH-1:0] fifo_count
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = $clog2(DEPTH);
    // Entry layout, MSB first: {tdata, tstrb, tkeep, tlast, tuser}
    localparam int ENTRY_WIDTH = DATA_WIDTH + 2 * STRB_WIDTH + 1 + USER_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0] count_reg,  count_next;

    logic                   tready;
    logic                   head_valid;
    logic                   accept;
    logic                   null_beat;
    logic                   wr_en;
    logic                   rd_en;
    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic [ENTRY_WIDTH-1:0] head_entry;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // tready depends only on the registered count (plus flush and reset), so
    // there is no combinational path from bk_ready: a read while full frees
    // the slot for the following cycle, not the current one. Gating with
    // axi_aresetn keeps tready low for as long as reset is held.
    assign tready     = axi_aresetn && (count_reg != FULL_COUNT) && !flush;
    assign head_valid = (count_reg != '0);
    assign accept     = bus.axis_tvalid && tready;

`ifdef AXIS_SLAVE_FIFO_NULL_DROP_EN
    assign null_beat = (bus.axis_tkeep == '0) && !bus.axis_tlast;
`else
    assign null_beat = 1'b0;
`endif

    assign wr_en = accept && !null_beat;
    // flush suppresses the read; the write is already blocked through tready.
    assign rd_en = head_valid && bus.bk_ready && !flush;

    assign wr_entry = {bus.axis_tdata, bus.axis_tstrb, bus.axis_tkeep,
                       bus.axis_tlast, bus.axis_tuser};

    // ------------------------------------------------------------------------
    // Storage. No reset on the array: stale contents are never visible
    // because the head is masked to zero whenever the FIFO is empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // Asynchronous read of the head so a beat written into an empty FIFO is
    // presented immediately after its write edge.
    assign head_entry = head_valid ? mem[rd_ptr_reg] : '0;

    // ------------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.axis_tready = tready;
    assign bus.bk_valid    = head_valid;
    assign fifo_count      = count_reg;

    assign {bus.bk_data, bus.bk_tstrb, bus.bk_tkeep, bus.bk_tlast, bus.bk_user} = head_entry;

endmodule

// File: tb/tb_axis_slave_fifo.sv
// ----------------------------------------------------------------------------
// tb_axis_slave_fifo
//
// Self-checking bench for axis_slave_fifo (DATA_WIDTH=32, USER_WIDTH=2,
// DEPTH=4). The reference model is a queue of beats: a write is a push, a
// read is a pop, a flush or reset empties it. Expected tready/valid/head/count
// are derived from the queue size and front entry.
// ----------------------------------------------------------------------------
module tb_axis_slave_fifo;
    localparam int DW    = 32;
    localparam int UW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic [DW/8-1:0] keep;
        logic            last;
        logic [UW-1:0]   user;
    } beat_t;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] fifo_count;

    axis_slave_fifo_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    axis_slave_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .flush       (flush),
        .bus         (bus),
        .fifo_count  (fifo_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    beat_t model_q[$];   // reference FIFO contents
    beat_t exp_rx[$];    // beats the model says the backend consumed
    beat_t dut_rx[$];    // beats actually observed leaving the DUT
    logic  obs_tready;   // DUT tready seen before the edge
    logic  exp_tready;   // model tready for the same cycle
    logic  last_accept;  // model: beat handshaken on the last edge

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.strb = 4'hF; b.keep = k; b.last = l; b.user = UW'(d);
        return b;
    endfunction

    function automatic logic is_dropped(input beat_t b);
`ifdef AXIS_SLAVE_FIFO_NULL_DROP_EN
        return (b.keep == '0) && !b.last;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive, sample the DUT before the edge, step the model.
    // Entered and left in the low phase of the clock.
    task automatic cycle(input logic tv, input beat_t b, input logic rdy, input logic fl);
        logic wr, rd;
        bus.axis_tvalid = tv;
        bus.axis_tdata  = b.data;
        bus.axis_tstrb  = b.strb;
        bus.axis_tkeep  = b.keep;
        bus.axis_tlast  = b.last;
        bus.axis_tuser  = b.user;
        bus.bk_ready    = rdy;
        flush           = fl;
        #1;
        obs_tready = bus.axis_tready;
        if (bus.bk_valid && rdy && !fl)
            dut_rx.push_back({bus.bk_data, bus.bk_tstrb, bus.bk_tkeep, bus.bk_tlast, bus.bk_user});
        exp_tready  = (model_q.size() != DEPTH) && !fl;
        last_accept = tv && exp_tready;
        wr = last_accept && !is_dropped(b);
        rd = (model_q.size() != 0) && rdy && !fl;
        @(posedge axi_aclk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (rd) exp_rx.push_back(model_q.pop_front());
            if (wr) model_q.push_back(b);
        end
        @(negedge axi_aclk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        bus.axis_tvalid = 1'b0; bus.axis_tdata = '0; bus.axis_tstrb = '0;
        bus.axis_tkeep = '0; bus.axis_tlast = 1'b0; bus.axis_tuser = '0;
        bus.bk_ready = 1'b0;
        axi_aresetn = 1'b0;
        repeat (2) @(negedge axi_aclk);
        n_cmp++;
        if (bus.axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL reset_tready_held: got %b want 0", bus.axis_tready);
        end
        axi_aresetn = 1'b1;
        #1;
        n_cmp++;
        if (bus.axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL reset_tready: got %b want 1", bus.axis_tready);
        end
        n_cmp++;
        if (bus.bk_valid !== 1'b0 || bus.bk_data !== '0) begin
            n_fail++; $display("FAIL reset_bk: got valid=%b data=%h want 0/0", bus.bk_valid, bus.bk_data);
        end
        n_cmp++;
        if (fifo_count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        model_q.delete();
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        dut_rx.delete(); exp_rx.delete();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, mk(i, 4'hF, i == 8), 1'b1, 1'b0);
            n_cmp++;
            if (obs_tready !== 1'b1) begin
                n_fail++; $display("FAIL stream_tready beat %0d: got %b want 1", i, obs_tready);
            end
            n_cmp++;
            if (bus.bk_valid !== 1'b1 || bus.bk_data !== 32'(i)) begin
                n_fail++; $display("FAIL stream_latency beat %0d: got valid=%b data=%h want 1/%h",
                                   i, bus.bk_valid, bus.bk_data, i);
            end
        end
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != 8) begin
            n_fail++; $display("FAIL stream_count: got %0d beats want 8", dut_rx.size());
        end
        for (int i = 0; i < dut_rx.size() && i < 8; i++) begin
            n_cmp++;
            if (dut_rx[i].data !== 32'(i + 1) || dut_rx[i].last !== (i == 7)) begin
                n_fail++; $display("FAIL stream_beat %0d: got data=%h last=%b want %h/%b",
                                   i, dut_rx[i].data, dut_rx[i].last, i + 1, i == 7);
            end
        end
        $display("test_streaming done: %0d beats", dut_rx.size());
    endtask

    task automatic test_backpressure();
        int idx = 0;
        dut_rx.delete(); exp_rx.delete();
        for (int c = 0; c < 20; c++) begin
            cycle(idx < 6, mk(32'h10 + idx, 4'hF, idx == 5), c >= 8, 1'b0);
            if (last_accept) idx++;
            n_cmp++;
            if (obs_tready !== exp_tready) begin
                n_fail++; $display("FAIL bp_tready cycle %0d: got %b want %b", c, obs_tready, exp_tready);
            end
            if (c == 6 || c == 8) begin
                n_cmp++;
                if (obs_tready !== 1'b0 || (c == 6 && fifo_count !== CW'(4))) begin
                    n_fail++; $display("FAIL bp_full cycle %0d: got tready=%b count=%0d want 0/4",
                                       c, obs_tready, fifo_count);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (obs_tready !== 1'b1) begin
                    n_fail++; $display("FAIL bp_after_read: got tready=%b want 1", obs_tready);
                end
            end
        end
        n_cmp++;
        if (dut_rx.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d beats want 6", dut_rx.size());
        end
        for (int i = 0; i < dut_rx.size() && i < 6; i++) begin
            n_cmp++;
            if (dut_rx[i].data !== 32'h10 + 32'(i)) begin
                n_fail++; $display("FAIL bp_order %0d: got %h want %h", i, dut_rx[i].data, 32'h10 + i);
            end
        end
        $display("test_backpressure done: %0d beats", dut_rx.size());
    endtask

    task automatic test_simultaneous();
        dut_rx.delete(); exp_rx.delete();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, mk(32'h20, 4'hF, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h21, 4'hF, 1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk(32'h22 + i, 4'hF, i == 2), 1'b1, 1'b0);
            n_cmp++;
            if (fifo_count !== CW'(2)) begin
                n_fail++; $display("FAIL simul_count step %0d: got %0d want 2", i, fifo_count);
            end
        end
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != 5) begin
            n_fail++; $display("FAIL simul_beats: got %0d want 5", dut_rx.size());
        end
        for (int i = 0; i < dut_rx.size() && i < 5; i++) begin
            n_cmp++;
            if (dut_rx[i].data !== 32'h20 + 32'(i)) begin
                n_fail++; $display("FAIL simul_order %0d: got %h want %h", i, dut_rx[i].data, 32'h20 + i);
            end
        end
        $display("test_simultaneous done: %0d beats", dut_rx.size());
    endtask

    task automatic test_flush();
        dut_rx.delete(); exp_rx.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h30 + i, 4'hF, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h99, 4'hF, 1'b1), 1'b1, 1'b1);
        n_cmp++;
        if (obs_tready !== 1'b0) begin
            n_fail++; $display("FAIL flush_tready: got %b want 0", obs_tready);
        end
        n_cmp++;
        if (bus.bk_valid !== 1'b0 || fifo_count !== '0 || bus.bk_data !== '0) begin
            n_fail++; $display("FAIL flush_state: got valid=%b count=%0d data=%h want 0/0/0",
                               bus.bk_valid, fifo_count, bus.bk_data);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != 0) begin
            n_fail++; $display("FAIL flush_leak: got %0d beats want 0", dut_rx.size());
        end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        dut_rx.delete(); exp_rx.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h40 + i, 4'hF, 1'b0), 1'b0, 1'b0);
        bus.axis_tvalid = 1'b0;
        @(posedge axi_aclk);
        #2;
        axi_aresetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.bk_valid !== 1'b0 || fifo_count !== '0 || bus.bk_data !== '0 || bus.axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL areset_state: got valid=%b count=%0d data=%h tready=%b want 0/0/0/0",
                               bus.bk_valid, fifo_count, bus.bk_data, bus.axis_tready);
        end
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        model_q.delete();
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != 0) begin
            n_fail++; $display("FAIL areset_leak: got %0d beats want 0", dut_rx.size());
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        beat_t pend, exp_head, got_head;
        logic  pend_v = 1'b0;
        dut_rx.delete(); exp_rx.delete();
        for (int c = 0; c < 400; c++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend.data = $urandom;
                pend.strb = 4'($urandom);
                pend.keep = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                pend.last = 1'($urandom);
                pend.user = UW'($urandom);
                pend_v    = 1'b1;
            end
            cycle(pend_v, pend, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            if (last_accept) pend_v = 1'b0;
            exp_head = (model_q.size() != 0) ? model_q[0] : '0;
            got_head = {bus.bk_data, bus.bk_tstrb, bus.bk_tkeep, bus.bk_tlast, bus.bk_user};
            n_cmp++;
            if (obs_tready !== exp_tready || fifo_count !== CW'(model_q.size()) ||
                bus.bk_valid !== (model_q.size() != 0) || got_head !== exp_head) begin
                n_fail++;
                $display("FAIL rand cycle %0d: got tready=%b count=%0d valid=%b head=%h want %b/%0d/%b/%h",
                         c, obs_tready, fifo_count, bus.bk_valid, got_head,
                         exp_tready, model_q.size(), model_q.size() != 0, exp_head);
            end
        end
        repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != exp_rx.size()) begin
            n_fail++; $display("FAIL rand_beats: got %0d want %0d", dut_rx.size(), exp_rx.size());
        end
        for (int i = 0; i < dut_rx.size() && i < exp_rx.size(); i++) begin
            n_cmp++;
            if (dut_rx[i] !== exp_rx[i]) begin
                n_fail++; $display("FAIL rand_beat %0d: got %h want %h", i, dut_rx[i], exp_rx[i]);
            end
        end
        $display("test_random done: %0d beats delivered", dut_rx.size());
    endtask

`ifdef AXIS_SLAVE_FIFO_NULL_DROP_EN
    task automatic test_null_drop();
        dut_rx.delete(); exp_rx.delete();
        cycle(1'b1, mk(32'hA, 4'hF, 1'b0), 1'b1, 1'b0);
        cycle(1'b1, mk(32'hB, 4'h0, 1'b0), 1'b1, 1'b0);
        n_cmp++;
        if (obs_tready !== 1'b1) begin
            n_fail++; $display("FAIL null_tready: got %b want 1", obs_tready);
        end
        cycle(1'b1, mk(32'hC, 4'h0, 1'b1), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (dut_rx.size() != 2) begin
            n_fail++; $display("FAIL null_beats: got %0d want 2", dut_rx.size());
        end else begin
            n_cmp++;
            if (dut_rx[0].data !== 32'hA || dut_rx[1].data !== 32'hC || dut_rx[1].last !== 1'b1) begin
                n_fail++; $display("FAIL null_seq: got %h,%h last=%b want a,c last=1",
                                   dut_rx[0].data, dut_rx[1].data, dut_rx[1].last);
            end
        end
        $display("test_null_drop done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
`ifdef AXIS_SLAVE_FIFO_NULL_DROP_EN
        test_null_drop();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
